// File: rtl/reg_access_sequencer_pkg.sv
// Shared opcode and state encodings for the register-file access sequencer.
// Default widths for the top level and its ALU.
package reg_access_sequencer_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 3;
   localparam int IMM_W_DEF  = 8;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_NOT = 3'b101,
      OP_MOV = 3'b110,
      OP_LDI = 3'b111
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_EXEC = 2'd2,
      ST_WB   = 2'd3
   } state_t;

endpackage

// File: rtl/reg_access_sequencer_alu.sv
// Combinational ALU for the sequencer. The carry output is only meaningful
// for ADD (carry out) and SUB (borrow); it is 0 for every other opcode.
module seq_alu
   import reg_access_sequencer_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int IMM_W  = IMM_W_DEF
) (
   input  op_t               op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [IMM_W-1:0]  imm,
   output logic [DATA_W-1:0] result,
   output logic              carry
);

   logic [DATA_W:0] wide;

   always_comb begin
      wide   = '0;
      result = '0;
      carry  = 1'b0;
      case (op)
         OP_ADD: begin
            wide   = {1'b0, a} + {1'b0, b};
            result = wide[DATA_W-1:0];
            carry  = wide[DATA_W];
         end
         // Bit DATA_W of the extended difference is set exactly when a < b.
         OP_SUB: begin
            wide   = {1'b0, a} - {1'b0, b};
            result = wide[DATA_W-1:0];
            carry  = wide[DATA_W];
         end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_NOT:  result = ~a;
         OP_MOV:  result = a;
         OP_LDI:  result = {{(DATA_W-IMM_W){1'b0}}, imm};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/reg_access_sequencer.sv
// Initiator for the internal register file: one instruction per four cycles,
// read -> execute -> write-back, with all strobes registered.
//
// state   | meaning
// IDLE    | in_ready=1, waiting for in_valid; latches the instruction
// READ    | en_reg=1, rA/rB presented, file registers regA/regB
// EXEC    | ALU works on regA/regB; result and flags registered
// WB      | regD_wr=1 and done=1 for one cycle
module reg_access_sequencer
   import reg_access_sequencer_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int IMM_W  = IMM_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_op,
   input  logic [ADDR_W-1:0] in_rd,
   input  logic [ADDR_W-1:0] in_ra,
   input  logic [ADDR_W-1:0] in_rb,
   input  logic [IMM_W-1:0]  in_imm,
   output logic              en_reg,
   output logic [ADDR_W-1:0] rA,
   output logic [ADDR_W-1:0] rB,
   input  logic [DATA_W-1:0] regA,
   input  logic [DATA_W-1:0] regB,
   output logic              regD_wr,
   output logic [ADDR_W-1:0] rD,
   output logic [DATA_W-1:0] regD,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic              flag_z,
   output logic              flag_c
);

   state_t              state;
   op_t                 op_q;
   logic [ADDR_W-1:0]   rd_q;
   logic [IMM_W-1:0]    imm_q;
   logic [DATA_W-1:0]   alu_result;
   logic                alu_carry;

   assign in_ready = (state == ST_IDLE);

   seq_alu #(.DATA_W(DATA_W), .IMM_W(IMM_W)) u_alu (
      .op     (op_q),
      .a      (regA),
      .b      (regB),
      .imm    (imm_q),
      .result (alu_result),
      .carry  (alu_carry)
   );

   // rA/rB double as the latched source addresses; they only change on accept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         op_q    <= OP_ADD;
         rd_q    <= '0;
         imm_q   <= '0;
         en_reg  <= 1'b0;
         rA      <= '0;
         rB      <= '0;
         regD_wr <= 1'b0;
         rD      <= '0;
         regD    <= '0;
         done    <= 1'b0;
         result  <= '0;
         flag_z  <= 1'b0;
         flag_c  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  op_q   <= op_t'(in_op);
                  rd_q   <= in_rd;
                  imm_q  <= in_imm;
                  rA     <= in_ra;
                  rB     <= in_rb;
                  en_reg <= 1'b1;
                  state  <= ST_READ;
               end
            end
            ST_READ: begin
               en_reg <= 1'b0;
               state  <= ST_EXEC;
            end
            ST_EXEC: begin
               result  <= alu_result;
               flag_z  <= (alu_result == '0);
               flag_c  <= alu_carry;
               regD    <= alu_result;
               rD      <= rd_q;
               regD_wr <= 1'b1;
               done    <= 1'b1;
               state   <= ST_WB;
            end
            ST_WB: begin
               regD_wr <= 1'b0;
               done    <= 1'b0;
               state   <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
